// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit. Steps each instruction through T0..T7 and drives
//   the register select/encode strobes, bus enables, memory strobes and the
//   ALU function code consumed by the datapath.
//
//   Ports
//     clock      in   system clock, all state updates on posedge
//     clear      in   synchronous active-high reset; abandons any instruction
//     ir         in   instruction register, opcode in ir[31:27]
//     con_ff     in   branch condition flip-flop
//     mem_ready  in   memory done strobe (only used when MEM_WAIT_EN is defined)
//     stop       in   level; while high the sequencer parks in T0
//     run        out  1 = executing, 0 = halted or parked
//     pc_out .. con_in, mem_read, mem_write       datapath/bus/memory strobes
//     gra, grb, grc, r_in, r_out, ba_out, c_out   select/encode controls
//     alu_op     out  ALU function code
//
//   Build option
//     MEM_WAIT_EN  when defined, memory states (T1, ld T6, st T7) hold until
//                  mem_ready=1; otherwise every memory state lasts one cycle.
//
//   Outputs are a decode of the state register plus the opcode. clear and a
//   parked T0 (stop high) force every strobe low so the datapath sees a
//   quiet cycle. The opcode must be visible on ir by T2, because T2 decides
//   whether the instruction ends early (nop) or halts.
module control_sequencer #(
  parameter int unsigned     OPW    = 5,
  parameter logic [OPW-1:0]  ADD_OP = 5'b00011
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           run,
  output logic           pc_out,
  output logic           pc_in,
  output logic           inc_pc,
  output logic           mar_in,
  output logic           mdr_in,
  output logic           mdr_out,
  output logic           ir_in,
  output logic           y_in,
  output logic           z_in,
  output logic           zlo_out,
  output logic           con_in,
  output logic           mem_read,
  output logic           mem_write,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic           ba_out,
  output logic           c_out,
  output logic [OPW-1:0] alu_op
);

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  state_e         state_q;
  state_e         state_d;

  logic [OPW-1:0] opcode_s;
  logic           is_ld_s;
  logic           is_ldi_s;
  logic           is_st_s;
  logic           is_alu_s;
  logic           is_imm_s;
  logic           is_br_s;
  logic           is_jr_s;
  logic           is_halt_s;
  logic           is_exec_s;
  logic           mem_go_s;
  logic           unused_s;

  assign opcode_s  = ir[31:32-OPW];
  assign is_ld_s   = (opcode_s == 5'b00000);
  assign is_ldi_s  = (opcode_s == 5'b00001);
  assign is_st_s   = (opcode_s == 5'b00010);
  assign is_alu_s  = (opcode_s >= 5'b00011) && (opcode_s <= 5'b01011);
  assign is_imm_s  = (opcode_s >= 5'b01100) && (opcode_s <= 5'b01110);
  assign is_br_s   = (opcode_s == 5'b10010);
  assign is_jr_s   = (opcode_s == 5'b10100);
  assign is_halt_s = (opcode_s == 5'b11011);
  // Anything not listed here (including the explicit nop) ends after fetch.
  assign is_exec_s = is_ld_s | is_ldi_s | is_st_s | is_alu_s | is_imm_s |
                     is_br_s | is_jr_s;

`ifdef MEM_WAIT_EN
  assign mem_go_s = mem_ready;
  assign unused_s = ^ir[31-OPW:0];
`else
  assign mem_go_s = 1'b1;
  assign unused_s = ^{ir[31-OPW:0], mem_ready};
`endif

  // State register: clear abandons whatever is in flight and restarts at T0.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: step sequence per opcode class, with memory stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_T0: begin
        if (stop) begin
          state_d = S_T0;
        end else begin
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (mem_go_s) begin
          state_d = S_T2;
        end else begin
          state_d = S_T1;
        end
      end
      S_T2: begin
        if (is_halt_s) begin
          state_d = S_HALT;
        end else if (is_exec_s) begin
          state_d = S_T3;
        end else begin
          state_d = S_T0;
        end
      end
      S_T3: begin
        if (is_jr_s) begin
          state_d = S_T0;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_ld_s || is_st_s || is_br_s) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (is_ld_s) begin
          if (mem_go_s) begin
            state_d = S_T7;
          end else begin
            state_d = S_T6;
          end
        end else if (is_st_s) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_st_s && !mem_go_s) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  // Run flag: low only while halted or parked in T0 by stop; clear wins.
  always_comb begin
    if (clear) begin
      run = 1'b1;
    end else if (state_q == S_HALT) begin
      run = 1'b0;
    end else if ((state_q == S_T0) && stop) begin
      run = 1'b0;
    end else begin
      run = 1'b1;
    end
  end

  // Control decode: one bus driver at most per step, strobes quiet under clear.
  always_comb begin
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlo_out   = 1'b0;
    con_in    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    r_in      = 1'b0;
    r_out     = 1'b0;
    ba_out    = 1'b0;
    c_out     = 1'b0;
    alu_op    = {OPW{1'b0}};
    if (clear) begin
      alu_op = {OPW{1'b0}};
    end else begin
      case (state_q)
        S_T0: begin
          if (!stop) begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
          end else begin
            pc_out = 1'b0;
          end
        end
        S_T1: begin
          mem_read = 1'b1;
          mdr_in   = 1'b1;
        end
        S_T2: begin
          mdr_out = 1'b1;
          ir_in   = 1'b1;
        end
        S_T3: begin
          if (is_jr_s) begin
            gra   = 1'b1;
            r_out = 1'b1;
            pc_in = 1'b1;
          end else if (is_br_s) begin
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
          end else if (is_ld_s || is_ldi_s || is_st_s) begin
            // Base register, or zero when the base field is r0.
            grb    = 1'b1;
            ba_out = 1'b1;
            y_in   = 1'b1;
          end else if (is_alu_s || is_imm_s) begin
            grb   = 1'b1;
            r_out = 1'b1;
            y_in  = 1'b1;
          end else begin
            grb = 1'b0;
          end
        end
        S_T4: begin
          if (is_alu_s) begin
            grc    = 1'b1;
            r_out  = 1'b1;
            z_in   = 1'b1;
            alu_op = opcode_s;
          end else if (is_imm_s) begin
            c_out  = 1'b1;
            z_in   = 1'b1;
            alu_op = opcode_s;
          end else if (is_ld_s || is_ldi_s || is_st_s) begin
            c_out  = 1'b1;
            z_in   = 1'b1;
            alu_op = ADD_OP;
          end else if (is_br_s) begin
            pc_out = 1'b1;
            y_in   = 1'b1;
          end else begin
            z_in = 1'b0;
          end
        end
        S_T5: begin
          if (is_alu_s || is_imm_s || is_ldi_s) begin
            zlo_out = 1'b1;
            gra     = 1'b1;
            r_in    = 1'b1;
          end else if (is_ld_s || is_st_s) begin
            zlo_out = 1'b1;
            mar_in  = 1'b1;
          end else if (is_br_s) begin
            c_out  = 1'b1;
            z_in   = 1'b1;
            alu_op = ADD_OP;
          end else begin
            zlo_out = 1'b0;
          end
        end
        S_T6: begin
          if (is_ld_s) begin
            mem_read = 1'b1;
            mdr_in   = 1'b1;
          end else if (is_st_s) begin
            gra    = 1'b1;
            r_out  = 1'b1;
            mdr_in = 1'b1;
          end else if (is_br_s && con_ff) begin
            // Branch taken: the computed target goes to the PC.
            zlo_out = 1'b1;
            pc_in   = 1'b1;
          end else begin
            pc_in = 1'b0;
          end
        end
        S_T7: begin
          if (is_ld_s) begin
            mdr_out = 1'b1;
            gra     = 1'b1;
            r_in    = 1'b1;
          end else if (is_st_s) begin
            mem_write = 1'b1;
          end else begin
            mem_write = 1'b0;
          end
        end
        S_HALT:  alu_op = {OPW{1'b0}};
        default: alu_op = {OPW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer. For each instruction a list of
// expected control words (one per clock) is built from the step table of the
// instruction set, together with the stop/mem_ready/clear inputs for those
// cycles. The driver plays the list and pushes each expected word into a
// scoreboard queue; an independent monitor pops and compares on the falling
// edge.
module tb_control_sequencer;

  localparam int W = 26;
  typedef logic [W-1:0] vec_t;

  localparam vec_t M_RUN     = 26'd1 << 25;
  localparam vec_t M_PC_OUT  = 26'd1 << 24;
  localparam vec_t M_PC_IN   = 26'd1 << 23;
  localparam vec_t M_INC_PC  = 26'd1 << 22;
  localparam vec_t M_MAR_IN  = 26'd1 << 21;
  localparam vec_t M_MDR_IN  = 26'd1 << 20;
  localparam vec_t M_MDR_OUT = 26'd1 << 19;
  localparam vec_t M_IR_IN   = 26'd1 << 18;
  localparam vec_t M_Y_IN    = 26'd1 << 17;
  localparam vec_t M_Z_IN    = 26'd1 << 16;
  localparam vec_t M_ZLO_OUT = 26'd1 << 15;
  localparam vec_t M_CON_IN  = 26'd1 << 14;
  localparam vec_t M_MEM_RD  = 26'd1 << 13;
  localparam vec_t M_MEM_WR  = 26'd1 << 12;
  localparam vec_t M_GRA     = 26'd1 << 11;
  localparam vec_t M_GRB     = 26'd1 << 10;
  localparam vec_t M_GRC     = 26'd1 << 9;
  localparam vec_t M_R_IN    = 26'd1 << 8;
  localparam vec_t M_R_OUT   = 26'd1 << 7;
  localparam vec_t M_BA_OUT  = 26'd1 << 6;
  localparam vec_t M_C_OUT   = 26'd1 << 5;
  localparam logic [4:0] ADD_OP = 5'b00011;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    vec_t exp;
    bit   stp;
    bit   mrdy;
    bit   clr;
  } cyc_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_ready;
  logic        stop;
  logic        run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlo_out, con_in, mem_read, mem_write;
  logic        gra, grb, grc, r_in, r_out, ba_out, c_out;
  logic [4:0]  alu_op;

  cyc_t        pl[$];
  vec_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ir_v;
  bit          con_v;
  vec_t        dut_vec;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop), .run(run),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .z_in(z_in), .zlo_out(zlo_out), .con_in(con_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
    .ba_out(ba_out), .c_out(c_out), .alu_op(alu_op)
  );

  always #5 clock = ~clock;

  assign dut_vec = {run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
                    y_in, z_in, zlo_out, con_in, mem_read, mem_write,
                    gra, grb, grc, r_in, r_out, ba_out, c_out, alu_op};

  function automatic vec_t alu(input logic [4:0] op);
    return {21'd0, op};
  endfunction

  function automatic int stl(input int n);
    return WAIT_EN ? n : 0;
  endfunction

  task automatic add_cyc(input vec_t e, input bit mr, input bit sp);
    cyc_t c;
    c.exp = e; c.stp = sp; c.mrdy = mr; c.clr = 1'b0;
    pl.push_back(c);
  endtask

  task automatic add_run(input vec_t e);
    add_cyc(e | M_RUN, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic add_mem(input vec_t e, input int stalls);
    for (int i = 0; i < stalls; i++) add_cyc(e | M_RUN, 1'b0, 1'($urandom_range(0, 1)));
    add_cyc(e | M_RUN, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Expected cycle list for one instruction, straight from the step table.
  task automatic build(input logic [4:0] op, input bit con, input int t1s,
                       input int ms, input int npark, input int nhalt);
    pl.delete();
    for (int i = 0; i < npark; i++) add_cyc({W{1'b0}}, 1'($urandom_range(0, 1)), 1'b1);
    add_cyc(M_RUN | M_PC_OUT | M_MAR_IN | M_INC_PC, 1'($urandom_range(0, 1)), 1'b0);
    add_mem(M_MEM_RD | M_MDR_IN, t1s);
    add_run(M_MDR_OUT | M_IR_IN);
    if (op == 5'd0) begin
      add_run(M_GRB | M_BA_OUT | M_Y_IN);
      add_run(M_C_OUT | M_Z_IN | alu(ADD_OP));
      add_run(M_ZLO_OUT | M_MAR_IN);
      add_mem(M_MEM_RD | M_MDR_IN, ms);
      add_run(M_MDR_OUT | M_GRA | M_R_IN);
    end else if (op == 5'd1) begin
      add_run(M_GRB | M_BA_OUT | M_Y_IN);
      add_run(M_C_OUT | M_Z_IN | alu(ADD_OP));
      add_run(M_ZLO_OUT | M_GRA | M_R_IN);
    end else if (op == 5'd2) begin
      add_run(M_GRB | M_BA_OUT | M_Y_IN);
      add_run(M_C_OUT | M_Z_IN | alu(ADD_OP));
      add_run(M_ZLO_OUT | M_MAR_IN);
      add_run(M_GRA | M_R_OUT | M_MDR_IN);
      add_mem(M_MEM_WR, ms);
    end else if (op inside {[5'd3:5'd11]}) begin
      add_run(M_GRB | M_R_OUT | M_Y_IN);
      add_run(M_GRC | M_R_OUT | M_Z_IN | alu(op));
      add_run(M_ZLO_OUT | M_GRA | M_R_IN);
    end else if (op inside {[5'd12:5'd14]}) begin
      add_run(M_GRB | M_R_OUT | M_Y_IN);
      add_run(M_C_OUT | M_Z_IN | alu(op));
      add_run(M_ZLO_OUT | M_GRA | M_R_IN);
    end else if (op == 5'd18) begin
      add_run(M_GRA | M_R_OUT | M_CON_IN);
      add_run(M_PC_OUT | M_Y_IN);
      add_run(M_C_OUT | M_Z_IN | alu(ADD_OP));
      add_run(con ? (M_ZLO_OUT | M_PC_IN) : {W{1'b0}});
    end else if (op == 5'd20) begin
      add_run(M_GRA | M_R_OUT | M_PC_IN);
    end else if (op == 5'd27) begin
      for (int i = 0; i < nhalt; i++)
        add_cyc({W{1'b0}}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drive(input cyc_t c);
    @(posedge clock);
    #1;
    stop      = c.stp;
    mem_ready = c.mrdy;
    clear     = c.clr;
    ir        = ir_v;
    con_ff    = con_v;
    sb.push_back(c.exp);
  endtask

  task automatic drive_clear(input int n);
    cyc_t c;
    c.exp = M_RUN; c.clr = 1'b1;
    for (int i = 0; i < n; i++) begin
      c.stp  = 1'($urandom_range(0, 1));
      c.mrdy = 1'($urandom_range(0, 1));
      drive(c);
    end
  endtask

  // cut > 0 abandons the instruction with a clear after that many cycles.
  task automatic run_instr(input logic [4:0] op, input bit con, input int t1s,
                           input int ms, input int npark, input int nhalt,
                           input int cut);
    int lim;
    bit need_clr;
    build(op, con, stl(t1s), stl(ms), npark, nhalt);
    ir_v     = {op, 27'($urandom)};
    con_v    = con;
    lim      = pl.size();
    need_clr = (op == 5'd27);
    if (cut > 0 && cut < pl.size()) begin
      lim      = cut;
      need_clr = 1'b1;
    end
    for (int i = 0; i < lim; i++) drive(pl[i]);
    if (need_clr) drive_clear($urandom_range(1, 2));
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clock) begin : mon
    vec_t e;
    int   nd;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (dut_vec !== e) begin
        n_bad++;
        $display("FAIL ctrl_word #%0d: actual %h required %h (ir op %0d)",
                 n_cmp, dut_vec, e, ir[31:27]);
      end
      nd = $countones({pc_out, mdr_out, zlo_out, r_out, c_out, ba_out});
      n_cmp++;
      if (nd > 1) begin
        n_bad++;
        $display("FAIL bus_drivers #%0d: actual %0d drivers required at most 1", n_cmp, nd);
      end
    end
  end

  initial begin
    clear     = 1'b1;
    stop      = 1'b0;
    mem_ready = 1'b0;
    ir        = 32'd0;
    con_ff    = 1'b0;
    ir_v      = 32'd0;
    con_v     = 1'b0;

    drive_clear(2);
    // Directed cases.
    run_instr(5'd3,  1'b0, 0, 0, 0, 0, 0);   // add
    run_instr(5'd0,  1'b0, 0, 3, 0, 0, 0);   // ld with a 3-cycle stall
    run_instr(5'd2,  1'b0, 1, 2, 0, 0, 0);   // st with stalls
    run_instr(5'd18, 1'b0, 0, 0, 0, 0, 0);   // br not taken
    run_instr(5'd18, 1'b1, 0, 0, 0, 0, 0);   // br taken
    run_instr(5'd27, 1'b0, 0, 0, 0, 20, 0);  // halt, 20 cycles, clear
    run_instr(5'd3,  1'b0, 0, 0, 0, 0, 0);   // add, stop may rise mid-way
    run_instr(5'd20, 1'b0, 0, 0, 3, 0, 0);   // parked then jr
    run_instr(5'd26, 1'b0, 0, 0, 1, 0, 0);   // nop
    run_instr(5'd31, 1'b0, 0, 0, 0, 0, 0);   // undefined opcode
    run_instr(5'd0,  1'b0, 0, 2, 0, 0, 8);   // clear during the ld data stall

    for (int k = 0; k < 400; k++) begin
      logic [4:0] op;
      int t1s, ms, npark, nhalt, cut;
      op    = 5'($urandom_range(0, 31));
      t1s   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      ms    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      npark = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      nhalt = $urandom_range(1, 5);
      cut   = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 12) : 0;
      run_instr(op, 1'($urandom_range(0, 1)), t1s, ms, npark, nhalt, cut);
    end

    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d entries left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
